// File: rtl/qam_regbank_arbiter_if.sv
// rtl/qam_regbank_arbiter_if.sv - SPI, modulator and register-bank port bundle
interface qam_regbank_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              spi_req;
    logic              spi_we;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_wdata;
    logic              spi_ack;
    logic [DATA_W-1:0] spi_rdata;

    logic              mod_req;
    logic [ADDR_W-1:0] mod_addr;
    logic              mod_ack;
    logic [DATA_W-1:0] mod_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  spi_req, spi_we, spi_addr, spi_wdata,
        output spi_ack, spi_rdata,
        input  mod_req, mod_addr,
        output mod_ack, mod_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters and bank side
    modport master (
        output spi_req, spi_we, spi_addr, spi_wdata,
        input  spi_ack, spi_rdata,
        output mod_req, mod_addr,
        input  mod_ack, mod_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/qam_regbank_arbiter.sv
// rtl/qam_regbank_arbiter.sv - round-robin SPI/modulator arbiter for a single-port register bank
module qam_regbank_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    qam_regbank_arbiter_if.slave  bus,
    output logic [15:0]           conflict_cnt_o
);

    typedef enum logic [1:0] {IDLE, WR, RD, RDATA} state_t;
    typedef enum logic {OWN_SPI, OWN_MOD} owner_t;

    state_t            state_q;
    owner_t            owner_q;
    owner_t            last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              spi_ack_q;
    logic              mod_ack_q;
    logic [DATA_W-1:0] spi_rdata_q;
    logic [DATA_W-1:0] mod_rdata_q;
    logic [15:0]       conflict_cnt_q;
    logic [15:0]       conflict_cnt_d;
    logic              grant_spi;
    logic              grant_mod;
    logic              both_req;

    // Grant decision for the IDLE sample; a tie goes to whoever did not win last
    always_comb begin
        both_req  = bus.spi_req && bus.mod_req;
        grant_spi = bus.spi_req && (!bus.mod_req || (last_grant_q == OWN_MOD));
        grant_mod = bus.mod_req && !grant_spi;
    end

    // Transaction FSM; strobes and acks are registered so they line up with the state they belong to
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_MOD;
            last_grant_q <= OWN_MOD;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            spi_ack_q    <= 1'b0;
            mod_ack_q    <= 1'b0;
            spi_rdata_q  <= '0;
            mod_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    spi_ack_q <= 1'b0;
                    mod_ack_q <= 1'b0;
                    if (grant_spi) begin
                        owner_q      <= OWN_SPI;
                        last_grant_q <= OWN_SPI;
                        addr_q       <= bus.spi_addr;
                        wdata_q      <= bus.spi_wdata;
                        mem_en_q     <= 1'b1;
                        if (bus.spi_we) begin
                            mem_we_q  <= 1'b1;
                            spi_ack_q <= 1'b1;
                            state_q   <= WR;
                        end else begin
                            mem_we_q <= 1'b0;
                            state_q  <= RD;
                        end
                    end else if (grant_mod) begin
                        owner_q      <= OWN_MOD;
                        last_grant_q <= OWN_MOD;
                        addr_q       <= bus.mod_addr;
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= 1'b0;
                        state_q      <= RD;
                    end
                end
                WR: begin
                    mem_en_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    spi_ack_q <= 1'b0;
                    state_q   <= IDLE;
                end
                RD: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (owner_q == OWN_SPI) begin
                        spi_ack_q <= 1'b1;
                    end else begin
                        mod_ack_q <= 1'b1;
                    end
                    state_q <= RDATA;
                end
                RDATA: begin
                    spi_ack_q <= 1'b0;
                    mod_ack_q <= 1'b0;
                    if (owner_q == OWN_SPI) begin
                        spi_rdata_q <= bus.mem_rdata;
                    end else begin
                        mod_rdata_q <= bus.mem_rdata;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    mem_en_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    spi_ack_q <= 1'b0;
                    mod_ack_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Count IDLE cycles where both sides compete, sticking at all-ones
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if ((state_q == IDLE) && both_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // Conflict counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Bank read data arrives one cycle after the strobe, so it is passed straight through
    // during RDATA and latched on leaving it to hold the value between acks
    assign bus.spi_rdata = ((state_q == RDATA) && (owner_q == OWN_SPI)) ? bus.mem_rdata : spi_rdata_q;
    assign bus.mod_rdata = ((state_q == RDATA) && (owner_q == OWN_MOD)) ? bus.mem_rdata : mod_rdata_q;
    assign bus.spi_ack   = spi_ack_q;
    assign bus.mod_ack   = mod_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_qam_regbank_arbiter.sv
// tb/tb_qam_regbank_arbiter.sv - directed self-checking bench for qam_regbank_arbiter
module tb_qam_regbank_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] conflict_cnt;
    logic [15:0] mem [256];
    int          n_cmp;
    int          n_err;

    qam_regbank_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    qam_regbank_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    // Invariants checked every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (bus.spi_ack && bus.mod_ack) begin
                n_err++;
                $display("FAIL ack_overlap: spi_ack=%0b mod_ack=%0b required not both 1", bus.spi_ack, bus.mod_ack);
            end
            n_cmp++;
            if (bus.mem_we && !bus.mem_en) begin
                n_err++;
                $display("FAIL we_without_en: mem_we=%0b mem_en=%0b", bus.mem_we, bus.mem_en);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (bus.mem_en !== 1'b0)        begin n_err++; $display("FAIL rst_mem_en: got %0b want 0", bus.mem_en); end
        n_cmp++; if (bus.mem_we !== 1'b0)        begin n_err++; $display("FAIL rst_mem_we: got %0b want 0", bus.mem_we); end
        n_cmp++; if (bus.spi_ack !== 1'b0)       begin n_err++; $display("FAIL rst_spi_ack: got %0b want 0", bus.spi_ack); end
        n_cmp++; if (bus.mod_ack !== 1'b0)       begin n_err++; $display("FAIL rst_mod_ack: got %0b want 0", bus.mod_ack); end
        n_cmp++; if (bus.mem_addr !== 8'h00)     begin n_err++; $display("FAIL rst_mem_addr: got %h want 00", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 16'h0000) begin n_err++; $display("FAIL rst_mem_wdata: got %h want 0000", bus.mem_wdata); end
        n_cmp++; if (bus.spi_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_spi_rdata: got %h want 0000", bus.spi_rdata); end
        n_cmp++; if (bus.mod_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_mod_rdata: got %h want 0000", bus.mod_rdata); end
        n_cmp++; if (conflict_cnt !== 16'h0000)  begin n_err++; $display("FAIL rst_conflict_cnt: got %h want 0000", conflict_cnt); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus.mem_en, bus.spi_ack, bus.mod_ack} !== 3'b000) begin
                n_err++; $display("FAIL idle_quiet: en/spi_ack/mod_ack got %b want 000", {bus.mem_en, bus.spi_ack, bus.mod_ack});
            end
        end
    endtask

    task automatic test_spi_write();
        logic [15:0] pre_data [2];
        pre_data[0] = 16'h1111;
        pre_data[1] = 16'h2222;
        bus.spi_req = 1'b1; bus.spi_we = 1'b1; bus.spi_addr = 8'h3C; bus.spi_wdata = 16'hA5F0;
        step();
        n_cmp++; if (bus.mem_en !== 1'b1)         begin n_err++; $display("FAIL wr_mem_en: got %0b want 1", bus.mem_en); end
        n_cmp++; if (bus.mem_we !== 1'b1)         begin n_err++; $display("FAIL wr_mem_we: got %0b want 1", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 8'h3C)      begin n_err++; $display("FAIL wr_mem_addr: got %h want 3c", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 16'hA5F0)  begin n_err++; $display("FAIL wr_mem_wdata: got %h want a5f0", bus.mem_wdata); end
        n_cmp++; if (bus.spi_ack !== 1'b1)        begin n_err++; $display("FAIL wr_spi_ack: got %0b want 1", bus.spi_ack); end
        n_cmp++; if (bus.mod_ack !== 1'b0)        begin n_err++; $display("FAIL wr_mod_ack: got %0b want 0", bus.mod_ack); end
        bus.spi_req = 1'b0;
        step();
        n_cmp++; if (bus.spi_ack !== 1'b0)        begin n_err++; $display("FAIL wr_ack_single: got %0b want 0", bus.spi_ack); end
        n_cmp++; if (bus.mem_en !== 1'b0)         begin n_err++; $display("FAIL wr_en_single: got %0b want 0", bus.mem_en); end
        // Preload two locations used by the arbitration tests
        for (int i = 0; i < 2; i++) begin
            bus.spi_req = 1'b1; bus.spi_we = 1'b1; bus.spi_addr = 8'(i + 1); bus.spi_wdata = pre_data[i];
            step();
            n_cmp++; if (bus.spi_ack !== 1'b1) begin n_err++; $display("FAIL preload_ack%0d: got %0b want 1", i, bus.spi_ack); end
            bus.spi_req = 1'b0;
            step();
        end
    endtask

    task automatic test_spi_read();
        bus.spi_req = 1'b1; bus.spi_we = 1'b0; bus.spi_addr = 8'h3C;
        step();
        n_cmp++; if (bus.mem_en !== 1'b1)         begin n_err++; $display("FAIL rd_mem_en: got %0b want 1", bus.mem_en); end
        n_cmp++; if (bus.mem_we !== 1'b0)         begin n_err++; $display("FAIL rd_mem_we: got %0b want 0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 8'h3C)      begin n_err++; $display("FAIL rd_mem_addr: got %h want 3c", bus.mem_addr); end
        n_cmp++; if (bus.spi_ack !== 1'b0)        begin n_err++; $display("FAIL rd_early_ack: got %0b want 0", bus.spi_ack); end
        step();
        n_cmp++; if (bus.spi_ack !== 1'b1)        begin n_err++; $display("FAIL rd_spi_ack: got %0b want 1", bus.spi_ack); end
        n_cmp++; if (bus.spi_rdata !== 16'hA5F0)  begin n_err++; $display("FAIL rd_spi_rdata: got %h want a5f0", bus.spi_rdata); end
        n_cmp++; if (bus.mod_ack !== 1'b0)        begin n_err++; $display("FAIL rd_mod_ack: got %0b want 0", bus.mod_ack); end
        n_cmp++; if (bus.mem_en !== 1'b0)         begin n_err++; $display("FAIL rd_rdata_en: got %0b want 0", bus.mem_en); end
        bus.spi_req = 1'b0;
        step();
        n_cmp++; if (bus.spi_ack !== 1'b0)        begin n_err++; $display("FAIL rd_ack_single: got %0b want 0", bus.spi_ack); end
        n_cmp++; if (bus.spi_rdata !== 16'hA5F0)  begin n_err++; $display("FAIL rd_rdata_hold: got %h want a5f0", bus.spi_rdata); end
    endtask

    task automatic test_conflict();
        int order [2];
        int seen;
        do_reset();
        seen = 0;
        bus.spi_req = 1'b1; bus.spi_we = 1'b0; bus.spi_addr = 8'h01;
        bus.mod_req = 1'b1; bus.mod_addr = 8'h02;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            step();
            if (bus.spi_ack) begin
                order[seen] = 0; seen++;
                n_cmp++; if (bus.spi_rdata !== 16'h1111) begin n_err++; $display("FAIL cf_spi_rdata: got %h want 1111", bus.spi_rdata); end
                bus.spi_req = 1'b0;
            end else if (bus.mod_ack) begin
                order[seen] = 1; seen++;
                n_cmp++; if (bus.mod_rdata !== 16'h2222) begin n_err++; $display("FAIL cf_mod_rdata: got %h want 2222", bus.mod_rdata); end
                bus.mod_req = 1'b0;
            end
        end
        bus.spi_req = 1'b0; bus.mod_req = 1'b0;
        n_cmp++;
        if (seen != 2) begin
            n_err++; $display("FAIL cf_timeout: acks seen %0d want 2", seen);
        end else begin
            n_cmp++; if (order[0] != 0) begin n_err++; $display("FAIL cf_first: got %s want SPI", order[0] == 0 ? "SPI" : "MOD"); end
            n_cmp++; if (order[1] != 1) begin n_err++; $display("FAIL cf_second: got %s want MOD", order[1] == 0 ? "SPI" : "MOD"); end
        end
        n_cmp++; if (conflict_cnt !== 16'd1) begin n_err++; $display("FAIL cf_count: got %0d want 1", conflict_cnt); end
        step();
    endtask

    task automatic test_round_robin();
        int got;
        logic exp_spi;
        do_reset();
        got = 0;
        bus.spi_req = 1'b1; bus.spi_we = 1'b0; bus.spi_addr = 8'h01;
        bus.mod_req = 1'b1; bus.mod_addr = 8'h02;
        for (int c = 0; c < 40 && got < 6; c++) begin
            step();
            if (bus.spi_ack || bus.mod_ack) begin
                exp_spi = (got % 2) == 0;
                n_cmp++;
                if (bus.spi_ack !== exp_spi) begin
                    n_err++; $display("FAIL rr_grant%0d: spi_ack got %0b want %0b", got, bus.spi_ack, exp_spi);
                end
                n_cmp++;
                if (exp_spi && bus.spi_rdata !== 16'h1111) begin
                    n_err++; $display("FAIL rr_rdata%0d: spi_rdata got %h want 1111", got, bus.spi_rdata);
                end else if (!exp_spi && bus.mod_rdata !== 16'h2222) begin
                    n_err++; $display("FAIL rr_rdata%0d: mod_rdata got %h want 2222", got, bus.mod_rdata);
                end
                got++;
                if (got == 6) begin
                    bus.spi_req = 1'b0; bus.mod_req = 1'b0;
                end
            end
        end
        bus.spi_req = 1'b0; bus.mod_req = 1'b0;
        n_cmp++; if (got != 6) begin n_err++; $display("FAIL rr_timeout: acks seen %0d want 6", got); end
        step();
        n_cmp++; if (conflict_cnt !== 16'd6) begin n_err++; $display("FAIL rr_count: got %0d want 6", conflict_cnt); end
    endtask

    task automatic test_reset_abort();
        bus.mod_req = 1'b1; bus.mod_addr = 8'h02;
        step();
        n_cmp++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin n_err++; $display("FAIL ab_rd_cycle: en/we got %b want 10", {bus.mem_en, bus.mem_we}); end
        rst = 1'b1;
        step();
        n_cmp++; if (bus.mod_ack !== 1'b0)        begin n_err++; $display("FAIL ab_mod_ack: got %0b want 0", bus.mod_ack); end
        n_cmp++; if ({bus.mem_en, bus.mem_we, bus.spi_ack} !== 3'b000) begin n_err++; $display("FAIL ab_strobes: got %b want 000", {bus.mem_en, bus.mem_we, bus.spi_ack}); end
        n_cmp++; if (bus.mem_addr !== 8'h00)      begin n_err++; $display("FAIL ab_mem_addr: got %h want 00", bus.mem_addr); end
        n_cmp++; if (bus.mod_rdata !== 16'h0000)  begin n_err++; $display("FAIL ab_mod_rdata: got %h want 0000", bus.mod_rdata); end
        n_cmp++; if (bus.spi_rdata !== 16'h0000)  begin n_err++; $display("FAIL ab_spi_rdata: got %h want 0000", bus.spi_rdata); end
        n_cmp++; if (conflict_cnt !== 16'h0000)   begin n_err++; $display("FAIL ab_conflict_cnt: got %h want 0000", conflict_cnt); end
        rst = 1'b0;
        step();
        n_cmp++; if (bus.mem_en !== 1'b1)         begin n_err++; $display("FAIL ab_rerequest: mem_en got %0b want 1", bus.mem_en); end
        step();
        n_cmp++; if (bus.mod_ack !== 1'b1)        begin n_err++; $display("FAIL ab_reack: got %0b want 1", bus.mod_ack); end
        n_cmp++; if (bus.mod_rdata !== 16'h2222)  begin n_err++; $display("FAIL ab_rerdata: got %h want 2222", bus.mod_rdata); end
        bus.mod_req = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        force dut.conflict_cnt_q = 16'hFFFE;
        step();
        release dut.conflict_cnt_q;
        step();
        n_cmp++; if (conflict_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_preset: got %h want fffe", conflict_cnt); end
        bus.spi_req = 1'b1; bus.spi_we = 1'b0; bus.spi_addr = 8'h01;
        bus.mod_req = 1'b1; bus.mod_addr = 8'h02;
        step();
        n_cmp++; if (conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_first: got %h want ffff", conflict_cnt); end
        for (int c = 0; c < 12; c++) step();
        n_cmp++; if (conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
        bus.spi_req = 1'b0; bus.mod_req = 1'b0;
        for (int c = 0; c < 3; c++) step();
        n_cmp++; if (conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_idle: got %h want ffff", conflict_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.spi_req = 1'b0; bus.spi_we = 1'b0; bus.spi_addr = '0; bus.spi_wdata = '0;
        bus.mod_req = 1'b0; bus.mod_addr = '0;
        test_reset();
        test_spi_write();
        test_spi_read();
        test_conflict();
        test_round_robin();
        test_reset_abort();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qam_regbank_arbiter.md
QAM_REGBANK_ARBITER -- requirements
Module: qam_regbank_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, register bank address width (256 entries).
REQ-002 Parameter DATA_W, default 16, register word width.
REQ-003 clk  input  1  single clock for all logic; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 spi_req  input  1  SPI-side access request; held high until spi_ack.
REQ-006 spi_we  input  1  SPI access type: 1 = write, 0 = read; stable while spi_req is high.
REQ-007 spi_addr  input  ADDR_W  SPI access address; stable while spi_req is high.
REQ-008 spi_wdata  input  DATA_W  SPI write data; stable while spi_req is high.
REQ-009 spi_ack  output  1  one-cycle completion pulse for the SPI access.
REQ-010 spi_rdata  output  DATA_W  SPI read data; valid only while spi_ack is high after a read.
REQ-011 mod_req  input  1  modulator read request; the modulator side is read-only.
REQ-012 mod_addr  input  ADDR_W  modulator read address; stable while mod_req is high.
REQ-013 mod_ack  output  1  one-cycle completion pulse for the modulator read.
REQ-014 mod_rdata  output  DATA_W  modulator read data; valid only while mod_ack is high.
REQ-015 mem_en  output  1  bank access strobe.
REQ-016 mem_we  output  1  bank write strobe; only ever high together with mem_en.
REQ-017 mem_addr  output  ADDR_W  bank address.
REQ-018 mem_wdata  output  DATA_W  bank write data.
REQ-019 mem_rdata  input  DATA_W  bank read data; valid exactly 1 cycle after a read strobe.
REQ-020 conflict_cnt  output  16  saturating count of arbitration conflicts.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, WR, RD, RDATA.
REQ-022 Requests SHALL be sampled only in IDLE; requests in any other state SHALL be ignored.
REQ-023 Single request in IDLE SHALL be granted: SPI with spi_we=1 -> WR, SPI with spi_we=0 -> RD, modulator -> RD.
REQ-024 Both requests high in IDLE SHALL be resolved round-robin against last_grant: grant SPI if last_grant=MOD, else grant MOD.
REQ-025 last_grant SHALL be updated on every grant.
REQ-026 At grant, the address, write data, type and owner SHALL be captured into registers; inputs SHALL be ignored for the rest of the transaction.
REQ-027 WR state (1 cycle): mem_en=1, mem_we=1, mem_addr/mem_wdata from the captured values, spi_ack=1; next state IDLE.
REQ-028 RD state (1 cycle): mem_en=1, mem_we=0, mem_addr from the captured value, no ack; next state RDATA.
REQ-029 RDATA state (1 cycle), mem_en=0:
- the owner's rdata output SHALL equal mem_rdata and its ack SHALL be 1;
- next state IDLE.
REQ-030 Latency from request sampled in IDLE (cycle T): write ack at T+1; read ack at T+2; next request sampled no earlier than T+2 (write) or T+3 (read).
REQ-031 A requester SHALL drop req on the edge ending its ack cycle; a req still high in IDLE SHALL be treated as a new request.
REQ-032 spi_ack and mod_ack SHALL never be high in the same cycle; mem_en SHALL be high in at most one cycle per transaction.
REQ-033 spi_rdata and mod_rdata SHALL hold their last value outside ack cycles.
REQ-034 conflict_cnt SHALL increment by 1 in each IDLE cycle where spi_req and mod_req are both high, and SHALL saturate at 0xFFFF.
REQ-035 No request in IDLE: stay in IDLE with all strobes and acks low.

Reset
REQ-036 rst high at a clock edge SHALL force, with priority over any other transition:
- FSM = IDLE, last_grant = MOD;
- mem_en, mem_we, spi_ack, mod_ack = 0;
- mem_addr, mem_wdata, spi_rdata, mod_rdata = 0;
- conflict_cnt = 0.
REQ-037 Reset during WR, RD or RDATA SHALL abort the transaction with no ack issued; the requester SHALL re-request after reset.

Verification
REQ-038 SPI write addr 0x3C, data 0xA5F0, alone -> mem_en=mem_we=1, mem_addr=0x3C, mem_wdata=0xA5F0 at T+1; spi_ack at T+1 only.
REQ-039 SPI read addr 0x3C, bank model returns 0xA5F0 -> mem_en=1, mem_we=0 at T+1; spi_ack=1, spi_rdata=0xA5F0 at T+2; mod_ack stays 0.
REQ-040 After reset, SPI read 0x01 and mod read 0x02 raised simultaneously and held -> SPI served first, then MOD; conflict_cnt=1; acks never overlap.
REQ-041 Both requesters re-request continuously for 6 transactions -> grants alternate SPI, MOD, SPI, MOD, SPI, MOD; no requester is granted twice in a row.
REQ-042 rst asserted in the RD cycle of a mod read -> no mod_ack; next cycle all outputs 0, FSM IDLE, conflict_cnt=0.
REQ-043 Force conflict_cnt to 0xFFFE, then hold both requests for 3 IDLE samplings -> conflict_cnt=0xFFFF and stays there.
